// File: rtl/sw_prio_enc_pkg.sv
// Shared constants and helpers for the switch priority encoder and the
// downstream seven-segment decoder.
package seg_pkg;

    localparam int unsigned SEG_DIGITS = 8;
    localparam int unsigned NUM_W      = 3;
    localparam int unsigned DEB_CNT_W  = 20;
    localparam int unsigned BLINK_W    = 24;

    typedef logic [SEG_DIGITS-1:0] digit_vec_t;
    typedef logic [NUM_W-1:0]      num_t;

    // Index of the highest set bit; 0 when the vector is empty.
    function automatic num_t highest_set(input digit_vec_t v);
        num_t r;
        r = '0;
        for (int unsigned i = 0; i < SEG_DIGITS; i++) begin
            if (v[i]) r = num_t'(i);
        end
        return r;
    endfunction

    // Bar-graph mask: bits [n:0] set, higher bits clear.
    function automatic digit_vec_t bar_mask(input num_t n);
        digit_vec_t m;
        m = '0;
        for (int unsigned i = 0; i < SEG_DIGITS; i++) begin
            if (num_t'(i) <= n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/sw_prio_enc_if.sv
// Switch/display bus between the switch block and the encoder.
interface sw_prio_enc_if;
    import seg_pkg::*;

    logic [SEG_DIGITS-1:0] sw;
    logic                  blink_en;
    num_t                  num;
    digit_vec_t            seg_en;
    logic                  any;
    logic                  upd;

    modport master (
        output sw, blink_en,
        input  num, seg_en, any, upd
    );

    modport slave (
        input  sw, blink_en,
        output num, seg_en, any, upd
    );

endinterface

// File: rtl/sw_prio_enc_deb.sv
// Vector debouncer: 2-flop synchronizer followed by a stability counter.
// A new vector is accepted only after it is seen unchanged for DEB_CNT
// consecutive synchronized cycles.
module deb_vec
    import seg_pkg::*;
#(
    parameter int unsigned DEB_CNT = 50000,
    parameter int unsigned W       = SEG_DIGITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam logic [DEB_CNT_W-1:0] CNT_MAX = DEB_CNT_W'(DEB_CNT - 1);

    logic [W-1:0]         s1;
    logic [W-1:0]         s2;
    logic [W-1:0]         cand;
    logic [DEB_CNT_W-1:0] cnt;

    // Synchronize, then restart the count on any change of the candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= '0;
            s2   <= '0;
            cand <= '0;
            cnt  <= '0;
            dout <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else begin
                dout <= cand;
            end
        end
    end

endmodule

// File: rtl/sw_prio_enc.sv
// Switch priority encoder: debounces 8 switches, reports the highest set
// one as a digit index plus a bar-graph enable mask, optionally blinking.
module sw_prio_enc
    import seg_pkg::*;
#(
    parameter int unsigned DEB_CNT    = 50000,
    parameter int unsigned BLINK_HALF = 5000000
) (
    input  logic           clk,
    input  logic           rst_n,
    sw_prio_enc_if.slave   bus
);

    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_HALF - 1);

    digit_vec_t         stable;
    digit_vec_t         stable_d;
    logic [BLINK_W-1:0] bcnt;
    logic [BLINK_W-1:0] bcnt_nxt;
    logic               phase;
    logic               phase_nxt;
    logic               new_val;
    logic               any_nxt;
    num_t               num_nxt;
    digit_vec_t         seg_en_nxt;

    deb_vec #(
        .DEB_CNT (DEB_CNT),
        .W       (SEG_DIGITS)
    ) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.sw),
        .dout  (stable)
    );

    // Encode the debounced vector and advance the blink phase; the mask
    // uses the next phase so a freshly accepted value is shown at once.
    always_comb begin
        new_val   = (stable != stable_d);
        any_nxt   = |stable;
        num_nxt   = highest_set(stable);
        bcnt_nxt  = bcnt + 1'b1;
        phase_nxt = phase;
        if (new_val) begin
            bcnt_nxt  = '0;
            phase_nxt = 1'b1;
        end else if (bcnt == BLINK_MAX) begin
            bcnt_nxt  = '0;
            phase_nxt = ~phase;
        end
        seg_en_nxt = any_nxt ? bar_mask(num_nxt) : '0;
        if (bus.blink_en) seg_en_nxt = seg_en_nxt & {SEG_DIGITS{phase_nxt}};
    end

    // Register outputs and blink state; upd marks the first cycle of a
    // changed debounced vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d   <= '0;
            bcnt       <= '0;
            phase      <= 1'b1;
            bus.num    <= '0;
            bus.seg_en <= '0;
            bus.any    <= 1'b0;
            bus.upd    <= 1'b0;
        end else begin
            stable_d   <= stable;
            bcnt       <= bcnt_nxt;
            phase      <= phase_nxt;
            bus.num    <= num_nxt;
            bus.seg_en <= seg_en_nxt;
            bus.any    <= any_nxt;
            bus.upd    <= new_val;
        end
    end

endmodule

// File: tb/tb_sw_prio_enc.sv
// Bench for sw_prio_enc with DEB_CNT=4, BLINK_HALF=3.
module tb_sw_prio_enc;

    localparam int DEB = 4;
    localparam int BH  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sw_prio_enc_if bus();

    sw_prio_enc #(
        .DEB_CNT    (DEB),
        .BLINK_HALF (BH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: history of switch values applied before each edge
    // and the accepted vector after each edge since reset.
    logic [7:0] applied[$];
    logic [7:0] stab[$];
    int         k;
    int         m_bcnt;
    logic       m_phase;
    logic       cur_blink;
    logic [7:0] e_seg;
    logic [2:0] e_num;
    logic       e_any;
    logic       e_upd;

    typedef struct {
        logic [7:0] sw;
        logic [2:0] num;
        logic [7:0] seg;
        logic       any;
        logic       upd;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Synchronized switch value seen by the debouncer at edge j.
    function automatic logic [7:0] obs(input int j);
        if (j >= 3) return applied[j-3];
        return 8'h00;
    endfunction

    task automatic model_reset();
        applied.delete();
        stab.delete();
        stab.push_back(8'h00);
        k       = 0;
        m_bcnt  = 0;
        m_phase = 1'b1;
    endtask

    task automatic model_edge();
        logic [7:0] o;
        logic [7:0] v;
        bit         eq;
        int         n;
        k++;
        o  = obs(k);
        eq = 1'b1;
        for (int j = k - DEB; j < k; j++) if (obs(j) != o) eq = 1'b0;
        stab.push_back(eq ? o : stab[k-1]);
        v     = stab[k-1];
        e_upd = (k >= 2) && (stab[k-1] != stab[k-2]);
        if (e_upd) begin
            m_bcnt  = 0;
            m_phase = 1'b1;
        end else if (m_bcnt == BH - 1) begin
            m_bcnt  = 0;
            m_phase = ~m_phase;
        end else begin
            m_bcnt++;
        end
        e_any = (v != 0);
        n = 0;
        for (int i = 0; i < 8; i++) if (int'(v) >= (1 << i)) n = i;
        e_num = 3'(n);
        e_seg = e_any ? 8'((1 << (n + 1)) - 1) : 8'h00;
        if (cur_blink && !m_phase) e_seg = 8'h00;
    endtask

    task automatic step();
        applied.push_back(bus.sw);
        cur_blink = bus.blink_en;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("model", 32'({bus.upd, bus.any, bus.num, bus.seg_en}),
                       32'({e_upd, e_any, e_num, e_seg}));
    endtask

    initial begin
        int pulses;
        int cycles;
        bit found;

        tbl[0] = '{8'h24, 3'd5, 8'h3F, 1'b1, 1'b1};
        tbl[1] = '{8'h24, 3'd5, 8'h3F, 1'b1, 1'b0};
        tbl[2] = '{8'h01, 3'd0, 8'h01, 1'b1, 1'b1};
        tbl[3] = '{8'h80, 3'd7, 8'hFF, 1'b1, 1'b1};
        tbl[4] = '{8'h5A, 3'd6, 8'h7F, 1'b1, 1'b1};
        tbl[5] = '{8'h00, 3'd0, 8'h00, 1'b0, 1'b1};

        bus.sw       = 8'h00;
        bus.blink_en = 1'b0;
        model_reset();
        #1;
        check("reset_state", 32'({bus.upd, bus.any, bus.num, bus.seg_en}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset with switches off.
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.upd) pulses++;
        end
        check("idle_upd_pulses", 32'(pulses), 32'd0);
        check("idle_outputs", 32'({bus.any, bus.num, bus.seg_en}), 32'h0);

        // Table: each vector held DEB_CNT+4 edges, then one more edge.
        for (int t = 0; t < 6; t++) begin
            bus.sw = tbl[t].sw;
            pulses = 0;
            for (int i = 0; i < 7; i++) begin
                step();
                if (bus.upd) pulses++;
            end
            step();
            check("tbl_early_upd", 32'(pulses), 32'd0);
            check("tbl_num", 32'(bus.num), 32'(tbl[t].num));
            check("tbl_seg", 32'(bus.seg_en), 32'(tbl[t].seg));
            check("tbl_any", 32'(bus.any), 32'(tbl[t].any));
            check("tbl_upd", 32'(bus.upd), 32'(tbl[t].upd));
            step();
            check("tbl_upd_single", 32'(bus.upd), 32'd0);
        end

        // Short glitch from an all-off vector must be filtered.
        bus.sw = 8'h80;
        repeat (3) step();
        bus.sw = 8'h00;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.upd || bus.any) pulses++;
        end
        check("glitch_upd", 32'(pulses), 32'd0);
        check("glitch_outputs", 32'({bus.any, bus.num, bus.seg_en}), 32'h0);

        // Blink: 3 edges on, 3 edges off, starting at the update edge.
        bus.blink_en = 1'b1;
        bus.sw       = 8'h01;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bus.upd) found = 1'b1;
        end
        check("blink_upd_seen", 32'(found), 32'd1);
        check("blink_i0", 32'({bus.any, bus.num, bus.seg_en}), 32'({1'b1, 3'd0, 8'h01}));
        for (int i = 1; i < 12; i++) begin
            step();
            check("blink_pattern", 32'({bus.any, bus.num, bus.seg_en}),
                  32'({1'b1, 3'd0, ((i / 3) % 2 == 0) ? 8'h01 : 8'h00}));
        end

        // New value during the off phase is shown immediately.
        check("offphase_seg", 32'(bus.seg_en), 32'h0);
        bus.sw = 8'h08;
        found  = 1'b0;
        cycles = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            cycles++;
            if (bus.upd) found = 1'b1;
        end
        check("offphase_latency", 32'(cycles), 32'd8);
        check("offphase_seg_on", 32'(bus.seg_en), 32'h0F);
        check("offphase_num", 32'(bus.num), 32'd3);

        // Reset in the middle of debouncing 8'hFF.
        bus.blink_en = 1'b0;
        bus.sw       = 8'hFF;
        repeat (2) step();
        #2 rst_n = 1'b0;
        #1;
        check("midreset_outputs", 32'({bus.upd, bus.any, bus.num, bus.seg_en}), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        found  = 1'b0;
        cycles = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            cycles++;
            if (bus.upd) found = 1'b1;
        end
        check("postreset_latency", 32'(cycles), 32'd8);
        check("postreset_value", 32'({bus.any, bus.num, bus.seg_en}), 32'({1'b1, 3'd7, 8'hFF}));

        // Randomized holds against the reference model.
        for (int r = 0; r < 250; r++) begin
            int hold;
            hold = int'($urandom_range(1, 10));
            bus.sw = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 4) == 0) bus.blink_en = ~bus.blink_en;
            repeat (hold) step();
            if (r == 120) begin
                #2 rst_n = 1'b0;
                #1;
                check("rand_reset", 32'({bus.upd, bus.any, bus.num, bus.seg_en}), 32'h0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
